// File: rtl/pixel_hit_reader_pkg.sv
// Shared definitions for the pixel hit reader: upstream word layout, FSM states
// and the decoded-hit record stored in the FIFO.
package pixel_hit_reader_pkg;

  localparam int PIXEL_HIT_WORD_WIDTH = 46;
  localparam int PIXEL_HIT_DEC_WIDTH  = 45;

  localparam int PIX_ID_MSB = 45;
  localparam int PIX_ID_LSB = 38;
  localparam int EVT_MSB    = 37;
  localparam int EVT_LSB    = 30;
  localparam int TOA_MSB    = 29;
  localparam int TOA_LSB    = 20;
  localparam int TOT_MSB    = 19;
  localparam int TOT_LSB    = 11;
  localparam int CAL_MSB    = 10;
  localparam int CAL_LSB    = 1;
  localparam int HIT_BIT    = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } reader_state_e;

  typedef struct packed {
    logic [7:0] pixel_id;
    logic [7:0] event_tag;
    logic [9:0] toa;
    logic [8:0] tot;
    logic [9:0] cal;
  } pixel_hit_t;

  function automatic pixel_hit_t decode_hit(input logic [PIXEL_HIT_WORD_WIDTH-1:0] word);
    pixel_hit_t h;
    h.pixel_id  = word[PIX_ID_MSB:PIX_ID_LSB];
    h.event_tag = word[EVT_MSB:EVT_LSB];
    h.toa       = word[TOA_MSB:TOA_LSB];
    h.tot       = word[TOT_MSB:TOT_LSB];
    h.cal       = word[CAL_MSB:CAL_LSB];
    return h;
  endfunction

endpackage

// File: rtl/pixel_hit_reader_if.sv
// Upstream read bus plus the decoded-hit valid/ready stream of the pixel hit reader.
interface pixel_hit_reader_if;
  import pixel_hit_reader_pkg::*;

  logic                            dnUnreadHit;
  logic [PIXEL_HIT_WORD_WIDTH-1:0] dnData;
  logic                            dnRead;
  logic                            hitValid;
  logic                            hitReady;
  logic [7:0]                      hitPixelID;
  logic [7:0]                      hitEventTag;
  logic [9:0]                      hitTOA;
  logic [8:0]                      hitTOT;
  logic [9:0]                      hitCal;

  modport master (
    input  dnUnreadHit, dnData, hitReady,
    output dnRead, hitValid, hitPixelID, hitEventTag, hitTOA, hitTOT, hitCal
  );

  modport slave (
    output dnUnreadHit, dnData, hitReady,
    input  dnRead, hitValid, hitPixelID, hitEventTag, hitTOA, hitTOT, hitCal
  );

endinterface

// File: rtl/pixel_hit_fifo.sv
// Synchronous FIFO for decoded hits; head is read straight from storage.
module pixel_hit_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 45
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == (AW+1)'(0));
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still accepts a push in the same cycle as a pop
  assign do_push_s = push & (~full | do_pop_s);

  always_comb begin
    count_d = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      count_q <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_hit_reader.sv
// Polls the switch-cell chain, captures hit words after READ_LATENCY cycles and
// buffers decoded hits. Define PIXEL_ID_CHECK_EN to drop words with a foreign pixel ID.
module pixel_hit_reader
  import pixel_hit_reader_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         expPixelID,
  pixel_hit_reader_if.master bus,
  output logic [15:0]        readCount,
  output logic [15:0]        idErrCount,
  output logic               busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C    = (CW+1)'(FIFO_DEPTH);
  localparam logic [1:0]  LAT_LOAD_C = 2'(READ_LATENCY - 1);

  reader_state_e                   state_q, state_d;
  logic [1:0]                      lat_q, lat_d;
  logic [PIXEL_HIT_WORD_WIDTH-1:0] cap_q;
  logic                            dn_read_q, busy_q;
  logic [15:0]                     read_cnt_q, read_cnt_d;
  logic                            start_s, credit_s, id_ok_s, push_s, pop_s;
  logic                            fifo_empty_s, fifo_full_unused_s;
  logic [CW-1:0]                   fifo_count_s;
  logic [CW:0]                     occupancy_s;
  pixel_hit_t                      head_s, push_data_s;

  // The word in flight is counted against the FIFO so a capture can never overflow it
  assign occupancy_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, busy_q};
  assign credit_s    = (occupancy_s < DEPTH_C);
  assign start_s     = enable & bus.dnUnreadHit & credit_s;
  assign push_data_s = decode_hit(cap_q);
  assign pop_s       = ~fifo_empty_s & bus.hitReady;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_READ;
        else         state_d = ST_IDLE;
      end
      ST_READ: begin
        lat_d   = LAT_LOAD_C;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) state_d = ST_CAPTURE;
        else               lat_d   = lat_q - 2'd1;
      end
      // Chaining straight into the next read keeps spacing at READ_LATENCY+2
      ST_CAPTURE: begin
        if (start_s) state_d = ST_READ;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_cnt_d = read_cnt_q;
    push_s     = 1'b0;
    if (state_q == ST_CAPTURE) begin
      push_s = cap_q[HIT_BIT] & id_ok_s;
      if (read_cnt_q != 16'hFFFF) read_cnt_d = read_cnt_q + 16'd1;
      else                        read_cnt_d = read_cnt_q;
    end else begin
      push_s = 1'b0;
    end
  end

  // dnData is sampled on the edge that ends the last WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_q      <= 2'd0;
      cap_q      <= {PIXEL_HIT_WORD_WIDTH{1'b0}};
      dn_read_q  <= 1'b0;
      busy_q     <= 1'b0;
      read_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      dn_read_q  <= (state_d == ST_READ);
      busy_q     <= (state_d != ST_IDLE);
      read_cnt_q <= read_cnt_d;
      if (state_q == ST_WAIT && state_d == ST_CAPTURE) begin
        cap_q <= bus.dnData;
      end
    end
  end

`ifdef PIXEL_ID_CHECK_EN
  logic [15:0] id_err_q, id_err_d;
  logic        id_mismatch_s;

  assign id_mismatch_s = (cap_q[PIX_ID_MSB:PIX_ID_LSB] != expPixelID);
  assign id_ok_s       = ~id_mismatch_s;
  assign idErrCount    = id_err_q;

  always_comb begin
    id_err_d = id_err_q;
    if (state_q == ST_CAPTURE && cap_q[HIT_BIT] && id_mismatch_s && id_err_q != 16'hFFFF) begin
      id_err_d = id_err_q + 16'd1;
    end else begin
      id_err_d = id_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) id_err_q <= 16'd0;
    else       id_err_q <= id_err_d;
  end
`else
  logic unused_exp_id_s;
  assign unused_exp_id_s = ^expPixelID;
  assign id_ok_s         = 1'b1;
  assign idErrCount      = 16'h0000;
`endif

  pixel_hit_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (PIXEL_HIT_DEC_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (pop_s),
    .head     (head_s),
    .full     (fifo_full_unused_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  assign bus.dnRead      = dn_read_q;
  assign bus.hitValid    = ~fifo_empty_s;
  assign bus.hitPixelID  = head_s.pixel_id;
  assign bus.hitEventTag = head_s.event_tag;
  assign bus.hitTOA      = head_s.toa;
  assign bus.hitTOT      = head_s.tot;
  assign bus.hitCal      = head_s.cal;
  assign readCount       = read_cnt_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pixel_hit_reader.sv
// Directed bench for pixel_hit_reader: one instance at latency 1 with an upstream
// responder and pop scoreboard, one instance at latency 3 for capture timing.
module tb_pixel_hit_reader;
  import pixel_hit_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  expPixelID;
  logic [15:0] rc1, ie1, rc3, ie3;
  logic        busy1, busy3;

  pixel_hit_reader_if if1();
  pixel_hit_reader_if if3();

  pixel_hit_reader #(.FIFO_DEPTH(4), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .expPixelID(expPixelID),
    .bus(if1), .readCount(rc1), .idErrCount(ie1), .busy(busy1)
  );

  pixel_hit_reader #(.FIFO_DEPTH(4), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .expPixelID(expPixelID),
    .bus(if3), .readCount(rc3), .idErrCount(ie3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_pulses = 0;
  logic [44:0] exp_q [$];
  logic [45:0] stim_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] mk(input logic [7:0] pid, input logic [7:0] tag,
                                     input logic [9:0] toa, input logic [8:0] tot,
                                     input logic [9:0] cal, input logic hit);
    return {pid, tag, toa, tot, cal, hit};
  endfunction

  // One clock for dut1; a dnRead seen this cycle is answered with the next stimulus word
  task automatic step1();
    logic [45:0] cur;
    logic        keep;
    @(posedge clk); #1;
    if (if1.dnRead === 1'b1) begin
      rd_pulses++;
      if (stim_q.size() > 0) cur = stim_q.pop_front();
      else                   cur = mk(8'h15, 8'h00, 10'h000, 9'h000, 10'h000, 1'b0);
      if1.dnData = cur;
      keep = cur[0];
`ifdef PIXEL_ID_CHECK_EN
      if (cur[45:38] != expPixelID) keep = 1'b0;
`endif
      if (keep) exp_q.push_back(cur[45:1]);
    end
  endtask

  always @(negedge clk) begin
    logic [44:0] h;
    if (reset === 1'b0 && if1.hitValid === 1'b1 && if1.hitReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 64'(if1.hitPixelID), 64'hFFFF_FFFF);
      end else begin
        h = exp_q.pop_front();
        check("pop_word", 64'({if1.hitPixelID, if1.hitEventTag, if1.hitTOA, if1.hitTOT, if1.hitCal}), 64'(h));
      end
    end
  end

  initial begin
    int p0, t_rd, k, exp_ie, exp_seen;
    logic seen;
    logic [45:0] decoy, real_w;

    reset = 1'b1; enable = 1'b1; expPixelID = 8'h15;
    if1.dnUnreadHit = 1'b0; if1.dnData = 46'h0; if1.hitReady = 1'b1;
    if3.dnUnreadHit = 1'b0; if3.dnData = 46'h0; if3.hitReady = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_dnread",   64'(if1.dnRead),     64'd0);
    check("rst_valid",    64'(if1.hitValid),   64'd0);
    check("rst_pid",      64'(if1.hitPixelID), 64'd0);
    check("rst_readcnt",  64'(rc1),            64'd0);
    check("rst_iderr",    64'(ie1),            64'd0);
    check("rst_busy",     64'(busy1),          64'd0);
    check("rst_valid3",   64'(if3.hitValid),   64'd0);
    reset = 1'b0;
    step1();

    // single hit
    stim_q.push_back(mk(8'h15, 8'h07, 10'h155, 9'h0AA, 10'h2AA, 1'b1));
    p0 = rd_pulses; t_rd = -1; if1.dnUnreadHit = 1'b1;
    for (int t = 0; t < 12; t++) begin
      step1();
      if (t_rd < 0 && if1.dnRead === 1'b1) begin t_rd = t; if1.dnUnreadHit = 1'b0; end
      if (t_rd >= 0 && t == t_rd) check("single_busy_read", 64'(busy1), 64'd1);
      if (t_rd >= 0 && t == t_rd + 2) check("single_valid_early", 64'(if1.hitValid), 64'd0);
      if (t_rd >= 0 && t == t_rd + 3) begin
        check("single_valid", 64'(if1.hitValid),   64'd1);
        check("single_pid",   64'(if1.hitPixelID), 64'h15);
        check("single_toa",   64'(if1.hitTOA),     64'h155);
        check("single_tot",   64'(if1.hitTOT),     64'h0AA);
        check("single_cal",   64'(if1.hitCal),     64'h2AA);
        check("single_readcnt", 64'(rc1),          64'd1);
        check("single_busy_done", 64'(busy1),      64'd0);
      end
    end
    check("single_pulses", 64'(rd_pulses - p0), 64'd1);

    // hit flag 0: counted, not pushed
    stim_q.push_back(mk(8'h15, 8'h01, 10'h0F0, 9'h00F, 10'h0FF, 1'b0));
    t_rd = -1; seen = 1'b0; if1.dnUnreadHit = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step1();
      if (t_rd < 0 && if1.dnRead === 1'b1) begin t_rd = t; if1.dnUnreadHit = 1'b0; end
      seen = seen | (if1.hitValid === 1'b1);
    end
    check("hit0_valid_seen", 64'(seen), 64'd0);
    check("hit0_readcnt",    64'(rc1),  64'd2);

    // pixel-ID mismatch
`ifdef PIXEL_ID_CHECK_EN
    exp_ie = 1; exp_seen = 0;
`else
    exp_ie = 0; exp_seen = 1;
`endif
    stim_q.push_back(mk(8'h16, 8'h02, 10'h011, 9'h022, 10'h033, 1'b1));
    t_rd = -1; seen = 1'b0; if1.dnUnreadHit = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step1();
      if (t_rd < 0 && if1.dnRead === 1'b1) begin t_rd = t; if1.dnUnreadHit = 1'b0; end
      seen = seen | (if1.hitValid === 1'b1);
    end
    check("idchk_iderr",   64'(ie1),  64'(exp_ie));
    check("idchk_pushed",  64'(seen), 64'(exp_seen));
    check("idchk_readcnt", 64'(rc1),  64'd3);

    // enable low blocks reads
    enable = 1'b0; if1.dnUnreadHit = 1'b1; p0 = rd_pulses;
    repeat (6) step1();
    check("enable_blocks", 64'(rd_pulses - p0), 64'd0);

    // backpressure: four reads fill the FIFO, then reads stop until pops resume
    if1.hitReady = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++)
      stim_q.push_back(mk(8'h15, 8'(8'h40 + i), 10'(10'h100 + i), 9'(9'h080 + i), 10'(10'h200 + i), 1'b1));
    p0 = rd_pulses;
    repeat (30) step1();
    check("bp_pulses", 64'(rd_pulses - p0), 64'd4);
    check("bp_valid",  64'(if1.hitValid),   64'd1);
    if1.hitReady = 1'b1;
    repeat (40) step1();
    check("bp_resumed", 64'(rd_pulses - p0 > 4), 64'd1);
    if1.dnUnreadHit = 1'b0;
    repeat (10) step1();
    check("bp_drained",    64'(exp_q.size()), 64'd0);
    check("total_readcnt", 64'(rc1),          64'(rd_pulses));

    // reset while a read is in WAIT
    if1.hitReady = 1'b0;
    stim_q.push_back(mk(8'h15, 8'h55, 10'h055, 9'h055, 10'h055, 1'b1));
    stim_q.push_back(mk(8'h15, 8'h66, 10'h066, 9'h066, 10'h066, 1'b1));
    if1.dnUnreadHit = 1'b1; t_rd = -1;
    for (int t = 0; t < 10 && t_rd < 0; t++) begin
      step1();
      if (if1.dnRead === 1'b1) begin t_rd = t; if1.dnUnreadHit = 1'b0; end
    end
    repeat (4) step1();
    check("rstmid_preload", 64'(if1.hitValid), 64'd1);
    if1.dnUnreadHit = 1'b1; t_rd = -1;
    for (int t = 0; t < 10 && t_rd < 0; t++) begin
      step1();
      if (if1.dnRead === 1'b1) begin t_rd = t; if1.dnUnreadHit = 1'b0; end
    end
    check("rstmid_read_seen", 64'(t_rd >= 0), 64'd1);
    step1();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_dnread",  64'(if1.dnRead),     64'd0);
    check("rstmid_valid",   64'(if1.hitValid),   64'd0);
    check("rstmid_pid",     64'(if1.hitPixelID), 64'd0);
    check("rstmid_readcnt", 64'(rc1),            64'd0);
    check("rstmid_busy",    64'(busy1),          64'd0);
    exp_q.delete();
    reset = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step1();
      seen = seen | (if1.hitValid === 1'b1);
    end
    check("rstmid_no_capture", 64'(seen), 64'd0);
    check("rstmid_readcnt2",   64'(rc1),  64'd0);

    // latency 3: only the word present READ_LATENCY cycles after dnRead is captured
    decoy  = mk(8'h15, 8'hAA, 10'h3FF, 9'h1FF, 10'h3FF, 1'b1);
    real_w = mk(8'h15, 8'h33, 10'h0F0, 9'h10F, 10'h00F, 1'b1);
    if3.dnData = decoy; if3.dnUnreadHit = 1'b1; k = -1; p0 = 0;
    for (int t = 0; t < 14; t++) begin
      @(posedge clk); #1;
      if (if3.dnRead === 1'b1) p0++;
      if (k < 0 && if3.dnRead === 1'b1) begin k = t; if3.dnUnreadHit = 1'b0; end
      if (k >= 0 && t == k + 3) if3.dnData = real_w;
      if (k >= 0 && t == k + 4) begin
        check("lat3_valid_early", 64'(if3.hitValid), 64'd0);
        check("lat3_busy",        64'(busy3),        64'd1);
      end
      if (k >= 0 && t == k + 5) begin
        check("lat3_valid",   64'(if3.hitValid), 64'd1);
        check("lat3_word",    64'({if3.hitPixelID, if3.hitEventTag, if3.hitTOA, if3.hitTOT, if3.hitCal}),
                              64'(real_w[45:1]));
        check("lat3_busy_done", 64'(busy3),      64'd0);
        check("lat3_readcnt", 64'(rc3),          64'd1);
      end
    end
    check("lat3_pulses", 64'(p0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
